// File: rtl/bcd_scan_driver.sv
// Captures a 14-bit binary value, converts it to 4 BCD digits by iterative double-dabble,
// and scans the digits onto a shared BCD bus with active-low anodes. Optional macro: BCD_SCAN_BLANK_EN.
module bcd_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [13:0] value,
    output logic        busy,
    output logic        ovf,
    output logic [3:0]  digit_bcd,
    output logic [3:0]  an
);

    localparam int unsigned BIN_W   = 14;
    localparam int unsigned BCD_W   = 16;
    localparam int unsigned SH_W    = BCD_W + BIN_W;
    localparam int unsigned ITER_W  = 4;
    localparam int unsigned ITERS   = 14;
    localparam int unsigned CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned MAX_VAL = 9999;

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t            state;
    logic [SH_W-1:0]   shreg;
    logic [ITER_W-1:0] iter;
    logic [BCD_W-1:0]  disp;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        idx;

    logic [BCD_W-1:0]  adj;
    logic [SH_W-1:0]   shifted;
    logic [1:0]        idx_nxt;
    logic              cnt_wrap;
    logic [3:0]        lead_zero;
    logic [3:0]        an_nxt;
    logic [3:0]        digit_nxt;

    // One double-dabble iteration: add 3 to nibbles >= 5, then shift the whole register left.
    always_comb begin
        adj = shreg[SH_W-1:BIN_W];
        for (int i = 0; i < 4; i++) begin
            if (adj[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
            end
        end
        shifted = {adj[BCD_W-2:0], shreg[BIN_W-1:0], 1'b0};
    end

    // Scan position and digit selection for the upcoming slot.
    always_comb begin
        cnt_wrap  = (cnt == CNT_W'(REFRESH_DIV - 1));
        idx_nxt   = cnt_wrap ? idx + 2'd1 : idx;
        lead_zero = 4'b0000;
        lead_zero[3] = (disp[15:12] == 4'd0);
        lead_zero[2] = lead_zero[3] && (disp[11:8] == 4'd0);
        lead_zero[1] = lead_zero[2] && (disp[7:4] == 4'd0);
        an_nxt    = ~(4'b0001 << idx_nxt);
        digit_nxt = disp[{idx_nxt, 2'b00} +: 4];
`ifdef BCD_SCAN_BLANK_EN
        // Ones digit never blanks (lead_zero[0] stays 0), so a zero value shows one "0".
        if (lead_zero[idx_nxt]) begin
            an_nxt = 4'b1111;
        end
`endif
    end

    // Conversion FSM with capture, iteration and atomic commit to the display register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            iter  <= '0;
            disp  <= '0;
            busy  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state <= CONV;
                        busy  <= 1'b1;
                        iter  <= '0;
                        if (32'(value) > MAX_VAL) begin
                            shreg <= {16'd0, BIN_W'(MAX_VAL)};
                            ovf   <= 1'b1;
                        end else begin
                            shreg <= {16'd0, value};
                            ovf   <= 1'b0;
                        end
                    end
                end
                CONV: begin
                    shreg <= shifted;
                    if (iter == ITER_W'(ITERS - 1)) begin
                        disp  <= shifted[SH_W-1:BIN_W];
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        iter <= iter + ITER_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Free-running digit scanner; outputs registered and updated together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            idx       <= 2'd0;
            an        <= 4'b1110;
            digit_bcd <= 4'd0;
        end else begin
            cnt       <= cnt_wrap ? '0 : cnt + CNT_W'(1);
            idx       <= idx_nxt;
            an        <= an_nxt;
            digit_bcd <= digit_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Directed self-checking bench for bcd_scan_driver with REFRESH_DIV=4.
// Define BCD_SCAN_BLANK_EN for both files to exercise leading-zero blanking.
module tb_bcd_scan_driver;

    localparam int unsigned DIV = 4;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [13:0] value;
    logic        busy;
    logic        ovf;
    logic [3:0]  digit_bcd;
    logic [3:0]  an;

    int total;
    int bad;
    int cyc;

    bcd_scan_driver #(.REFRESH_DIV(DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .value     (value),
        .busy      (busy),
        .ovf       (ovf),
        .digit_bcd (digit_bcd),
        .an        (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; cyc counts edges since reset release to locate the scan slot.
    task automatic step();
        @(posedge clk);
        if (rst_n) cyc++;
        else cyc = 0;
        #1;
    endtask

    function automatic logic [3:0] exp_an(input int slot, input logic [15:0] d);
        logic [3:0] a;
        logic [15:0] upper;
        a = ~(4'b0001 << slot);
        upper = d >> (4 * slot);
`ifdef BCD_SCAN_BLANK_EN
        if (slot > 0 && upper == 16'd0) a = 4'b1111;
`endif
        return a;
    endfunction

    // Bounded wait for busy to fall; returns the number of edges it stayed high after capture.
    task automatic wait_done(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            step();
            n++;
        end
    endtask

    // Observe one full frame and check every slot's digit and anode pattern.
    task automatic scan_check(input string tag, input logic [15:0] d);
        int slot;
        logic [15:0] nib;
        for (int i = 0; i < 4 * DIV; i++) begin
            step();
            slot = (cyc / DIV) % 4;
            nib = (d >> (4 * slot)) & 16'h000f;
            chk({tag, "_digit"}, {12'd0, digit_bcd}, nib);
            chk({tag, "_an"}, {12'd0, an}, {12'd0, exp_an(slot, d)});
        end
    endtask

    task automatic capture(input logic [13:0] v);
        value = v;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        int n;
        total = 0;
        bad = 0;
        cyc = 0;
        rst_n = 1'b0;
        load = 1'b0;
        value = '0;

        // Reset
        repeat (3) step();
        chk("rst_an", {12'd0, an}, 16'h000e);
        chk("rst_digit", {12'd0, digit_bcd}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_ovf", {15'd0, ovf}, 16'd0);
        rst_n = 1'b1;
        repeat (3) step();
        chk("an_hold3", {12'd0, an}, 16'h000e);
        step();
        chk("an_after4", {12'd0, an}, 16'h000d);
        repeat (12) step();
        chk("an_after16", {12'd0, an}, 16'h000e);

        // Conversion of 1234
        capture(14'd1234);
        chk("conv_busy_e0", {15'd0, busy}, 16'd1);
        chk("conv_ovf", {15'd0, ovf}, 16'd0);
        wait_done(n);
        chk("conv_busy_len", 16'(n), 16'd14);
        scan_check("d1234", 16'h1234);

        // Overflow clamps to 9999
        capture(14'd12000);
        chk("ovf_set", {15'd0, ovf}, 16'd1);
        wait_done(n);
        chk("ovf_busy_len", 16'(n), 16'd14);
        scan_check("d9999", 16'h9999);
        capture(14'd7);
        chk("ovf_clr", {15'd0, ovf}, 16'd0);
        wait_done(n);
        scan_check("d0007", 16'h0007);

        // Loads while busy, including on the commit edge, are dropped
        capture(14'd5678);
        repeat (4) step();
        capture(14'd1111);
        repeat (8) step();
        chk("drop_busy_e13", {15'd0, busy}, 16'd1);
        capture(14'd1111);
        chk("drop_busy_e14", {15'd0, busy}, 16'd0);
        step();
        chk("drop_no_reassert1", {15'd0, busy}, 16'd0);
        step();
        chk("drop_no_reassert2", {15'd0, busy}, 16'd0);
        scan_check("d5678", 16'h5678);

        // Reset in the middle of a conversion
        capture(14'd9999);
        repeat (6) step();
        chk("midrst_busy_pre", {15'd0, busy}, 16'd1);
        rst_n = 1'b0;
        step();
        chk("midrst_busy", {15'd0, busy}, 16'd0);
        chk("midrst_an", {12'd0, an}, 16'h000e);
        chk("midrst_digit", {12'd0, digit_bcd}, 16'd0);
        rst_n = 1'b1;
        scan_check("d0000r", 16'h0000);
        chk("midrst_busy_post", {15'd0, busy}, 16'd0);

        // Leading-zero handling
        capture(14'd42);
        wait_done(n);
        scan_check("d0042", 16'h0042);
        capture(14'd0);
        wait_done(n);
        scan_check("d0000", 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
